// File: rtl/window_serializer_pkg.sv
// Types and default constants shared by the window serializer and its neighbours.
package window_serializer_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

    localparam int unsigned DefaultSize      = 3;
    localparam int unsigned DefaultDataWidth = 32;

endpackage

// File: rtl/window_serializer.sv
// Captures a SIZE-word parallel vector and emits it serially, highest word first,
// with a valid/ready handshake on both sides and gap-free back-to-back loads.
module window_serializer
    import window_serializer_pkg::*;
#(
    parameter int unsigned SIZE       = DefaultSize,
    parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [SIZE*DATA_WIDTH-1:0] data_in,
    input  logic                       load_valid,
    output logic                       load_ready,
    output logic [DATA_WIDTH-1:0]      shift_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       last
);

    localparam int unsigned     CntW    = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(SIZE - 1);

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   buf_q [SIZE];
    logic [DATA_WIDTH-1:0]   buf_d [SIZE];
    logic                    load_acc;
    logic                    xfer;

    always_comb begin
        out_valid  = (state_q == StShift);
        last       = out_valid && (cnt_q == '0);
        // Ready on the final transfer lets the next vector follow with no bubble.
        load_ready = !out_valid || (last && out_ready);
        load_acc   = load_valid && load_ready;
        xfer       = out_valid && out_ready;
        shift_out  = '0;
        for (int unsigned k = 0; k < SIZE; k++) begin
            if (cnt_q == CntW'(k)) begin
                shift_out = buf_q[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        if (xfer) begin
            if (last) begin
                state_d = StIdle;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
        if (load_acc) begin
            state_d = StShift;
            cnt_d   = LastIdx;
            for (int unsigned k = 0; k < SIZE; k++) begin
                buf_d[k] = data_in[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            for (int unsigned k = 0; k < SIZE; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_window_serializer.sv
// Randomized and directed bench for window_serializer, checked against a word-queue model
// and a behavioural downstream shift register fed by the serial output.
module tb_window_serializer;

    localparam int unsigned Size = 3;
    localparam int unsigned Dw   = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [Size*Dw-1:0] data_in = '0;
    logic              load_valid = 1'b0;
    logic              load_ready;
    logic [Dw-1:0]     shift_out;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              last;

    logic [Dw-1:0]     s1_data_in = '0;
    logic              s1_load_valid = 1'b0;
    logic              s1_load_ready;
    logic [Dw-1:0]     s1_shift_out;
    logic              s1_out_valid;
    logic              s1_out_ready = 1'b0;
    logic              s1_last;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [Dw-1:0]      exp_q [$];
    logic [Size*Dw-1:0] vec_q [$];
    logic [Size*Dw-1:0] sr = '0;

    always #5 clock = ~clock;

    window_serializer #(.SIZE(Size), .DATA_WIDTH(Dw)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .shift_out  (shift_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .last       (last)
    );

    window_serializer #(.SIZE(1), .DATA_WIDTH(Dw)) u_dut1 (
        .clock      (clock),
        .reset      (reset),
        .data_in    (s1_data_in),
        .load_valid (s1_load_valid),
        .load_ready (s1_load_ready),
        .shift_out  (s1_shift_out),
        .out_valid  (s1_out_valid),
        .out_ready  (s1_out_ready),
        .last       (s1_last)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive, check against the model, then advance the model on the edge.
    task automatic step(input logic lv, input logic [Size*Dw-1:0] din, input logic ordy);
        logic               mlr;
        logic [Size*Dw-1:0] exp_vec;
        @(negedge clock);
        load_valid = lv;
        data_in    = din;
        out_ready  = ordy;
        #1;
        mlr = (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
        check_eq("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
        check_eq("last", 128'(last), 128'(exp_q.size() == 1));
        check_eq("load_ready", 128'(load_ready), 128'(mlr));
        if (exp_q.size() != 0) begin
            check_eq("shift_out", 128'(shift_out), 128'(exp_q[0]));
        end
        if (out_valid && out_ready) begin
            sr = {sr[(Size-1)*Dw-1:0], shift_out};
            if (last) begin
                exp_vec = '0;
                if (vec_q.size() != 0) begin
                    exp_vec = vec_q.pop_front();
                end
                check_eq("loopback", 128'(sr), 128'(exp_vec));
            end
        end
        @(posedge clock);
        if (exp_q.size() != 0 && ordy) begin
            void'(exp_q.pop_front());
        end
        if (lv && mlr) begin
            for (int k = Size - 1; k >= 0; k--) begin
                exp_q.push_back(din[k*Dw +: Dw]);
            end
            vec_q.push_back(din);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        check_eq("rst_out_valid", 128'(out_valid), 128'(0));
        check_eq("rst_shift_out", 128'(shift_out), 128'(0));
        check_eq("rst_last", 128'(last), 128'(0));
        check_eq("rst_load_ready", 128'(load_ready), 128'(1));
        exp_q.delete();
        vec_q.delete();
        sr = '0;
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    localparam logic [Size*Dw-1:0] V1 = 96'h00000003_00000002_00000001;
    localparam logic [Size*Dw-1:0] V2 = 96'h0000000c_0000000b_0000000a;

    initial begin
        #3;
        apply_reset();

        // Single vector, free-flowing output.
        step(1'b1, V1, 1'b1);
        repeat (4) step(1'b0, '0, 1'b1);

        // Downstream stall on the first word.
        step(1'b1, V1, 1'b1);
        repeat (4) step(1'b0, '0, 1'b0);
        repeat (4) step(1'b0, '0, 1'b1);

        // load_valid held high: second vector must follow without a bubble.
        step(1'b1, V1, 1'b1);
        repeat (3) step(1'b1, V2, 1'b1);
        repeat (4) step(1'b0, '0, 1'b1);

        // Reset mid-vector, then a fresh load.
        step(1'b1, V1, 1'b1);
        step(1'b0, '0, 1'b1);
        apply_reset();
        step(1'b1, V2, 1'b1);
        repeat (4) step(1'b0, '0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom},
                 1'($urandom_range(0, 3) != 0));
        end
        repeat (6) step(1'b0, '0, 1'b1);

        // SIZE=1 instance: two back-to-back single-word vectors.
        @(negedge clock);
        s1_out_ready  = 1'b1;
        s1_load_valid = 1'b1;
        s1_data_in    = 32'hDEADBEEF;
        #1;
        check_eq("s1_idle_valid", 128'(s1_out_valid), 128'(0));
        check_eq("s1_idle_ready", 128'(s1_load_ready), 128'(1));
        @(negedge clock);
        s1_data_in = 32'h12345678;
        #1;
        check_eq("s1_w0_valid", 128'(s1_out_valid), 128'(1));
        check_eq("s1_w0_data", 128'(s1_shift_out), 128'(32'hDEADBEEF));
        check_eq("s1_w0_last", 128'(s1_last), 128'(1));
        check_eq("s1_w0_ready", 128'(s1_load_ready), 128'(1));
        @(negedge clock);
        s1_load_valid = 1'b0;
        #1;
        check_eq("s1_w1_valid", 128'(s1_out_valid), 128'(1));
        check_eq("s1_w1_data", 128'(s1_shift_out), 128'(32'h12345678));
        check_eq("s1_w1_last", 128'(s1_last), 128'(1));
        @(negedge clock);
        #1;
        check_eq("s1_done_valid", 128'(s1_out_valid), 128'(0));
        check_eq("s1_done_last", 128'(s1_last), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
